// File: rtl/cc_gearbox256_if.sv
// Interface bundles for the CC gearbox: user-side completion stream and AXI4-Stream CC port.
// With CC_GEARBOX_DISCONTINUE_EN defined, the user bundle also carries cc_discontinue.

interface cc_user_if;
    logic         cc_valid;
    logic         cc_ready;
    logic [95:0]  cc_descriptor;
    logic [255:0] cc_payload;
    logic [7:0]   cc_payload_dw_keep;
    logic         cc_payload_last;
`ifdef CC_GEARBOX_DISCONTINUE_EN
    logic         cc_discontinue;

    modport master (
        output cc_valid, cc_descriptor, cc_payload, cc_payload_dw_keep, cc_payload_last,
               cc_discontinue,
        input  cc_ready
    );
    modport slave (
        input  cc_valid, cc_descriptor, cc_payload, cc_payload_dw_keep, cc_payload_last,
               cc_discontinue,
        output cc_ready
    );
`else
    modport master (
        output cc_valid, cc_descriptor, cc_payload, cc_payload_dw_keep, cc_payload_last,
        input  cc_ready
    );
    modport slave (
        input  cc_valid, cc_descriptor, cc_payload, cc_payload_dw_keep, cc_payload_last,
        output cc_ready
    );
`endif
endinterface

interface cc_axis_if;
    logic [255:0] s_axis_cc_tdata;
    logic [7:0]   s_axis_cc_tkeep;
    logic         s_axis_cc_tvalid;
    logic         s_axis_cc_tlast;
    logic [32:0]  s_axis_cc_tuser;
    logic         s_axis_cc_tready;

    modport master (
        output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tvalid, s_axis_cc_tlast,
               s_axis_cc_tuser,
        input  s_axis_cc_tready
    );
    modport slave (
        input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tvalid, s_axis_cc_tlast,
               s_axis_cc_tuser,
        output s_axis_cc_tready
    );
endinterface

// File: rtl/cc_gearbox256.sv
// CC transmit gearbox: prepends the 96-bit descriptor and shifts payload up by three DWs.
// Optional feature macro: CC_GEARBOX_DISCONTINUE_EN (per-packet discontinue on tuser[0]).

module cc_gearbox256 #(
    parameter int DATA_WIDTH = 256
) (
    input  logic      clk,
    input  logic      rst_n,
    cc_user_if.slave  up,
    cc_axis_if.master dn
);
    localparam int NDW = DATA_WIDTH / 32;

    typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

    state_t       state_q, state_d;
    logic [95:0]  carry_q, carry_d;
    logic [7:0]   flush_keep_q, flush_keep_d;
    logic [255:0] tdata_q, tdata_d;
    logic [7:0]   tkeep_q, tkeep_d;
    logic         tlast_q, tlast_d;
    logic         tvalid_q, tvalid_d;
`ifdef CC_GEARBOX_DISCONTINUE_EN
    logic         disc_q, disc_d;
    logic         tuser0_q, tuser0_d;
`endif

    logic         slot_free;
    logic         accept;
    logic [3:0]   n_dw;
    logic [95:0]  low_dw;

    function automatic logic [7:0] dw_mask(input logic [3:0] k);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < NDW; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    assign slot_free    = !tvalid_q || dn.s_axis_cc_tready;
    assign up.cc_ready  = slot_free && (state_q != FLUSH);
    assign accept       = up.cc_valid && up.cc_ready;
    // First beat carries the descriptor in the low three DWs; later beats carry the previous spill.
    assign low_dw       = (state_q == IDLE) ? up.cc_descriptor : carry_q;

    always_comb begin
        n_dw = '0;
        for (int i = 0; i < NDW; i++) begin
            n_dw = n_dw + 4'(up.cc_payload_dw_keep[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        flush_keep_d = flush_keep_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tlast_d      = tlast_q;
        tvalid_d     = tvalid_q;
`ifdef CC_GEARBOX_DISCONTINUE_EN
        disc_d       = disc_q;
        tuser0_d     = tuser0_q;
`endif
        if (tvalid_q && dn.s_axis_cc_tready) begin
            tvalid_d = 1'b0;
        end

        unique case (state_q)
            IDLE, BODY: begin
                if (accept) begin
                    tdata_d  = {up.cc_payload[159:0], low_dw};
                    carry_d  = up.cc_payload[255:160];
                    tvalid_d = 1'b1;
`ifdef CC_GEARBOX_DISCONTINUE_EN
                    disc_d   = disc_q | up.cc_discontinue;
                    tuser0_d = 1'b0;
`endif
                    if (!up.cc_payload_last) begin
                        tkeep_d = 8'hFF;
                        tlast_d = 1'b0;
                        state_d = BODY;
                    end else if (n_dw <= 4'd5) begin
                        tkeep_d = dw_mask(n_dw + 4'd3);
                        tlast_d = 1'b1;
                        state_d = IDLE;
`ifdef CC_GEARBOX_DISCONTINUE_EN
                        tuser0_d = disc_q | up.cc_discontinue;
                        disc_d   = 1'b0;
`endif
                    end else begin
                        // Spill of n-5 DWs does not fit; emit it as a dedicated flush beat.
                        tkeep_d      = 8'hFF;
                        tlast_d      = 1'b0;
                        flush_keep_d = dw_mask(n_dw - 4'd5);
                        state_d      = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    tdata_d  = {160'b0, carry_q};
                    tkeep_d  = flush_keep_q;
                    tlast_d  = 1'b1;
                    tvalid_d = 1'b1;
                    state_d  = IDLE;
`ifdef CC_GEARBOX_DISCONTINUE_EN
                    tuser0_d = disc_q;
                    disc_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            carry_q      <= '0;
            flush_keep_q <= '0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
`ifdef CC_GEARBOX_DISCONTINUE_EN
            disc_q       <= 1'b0;
            tuser0_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            carry_q      <= carry_d;
            flush_keep_q <= flush_keep_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
`ifdef CC_GEARBOX_DISCONTINUE_EN
            disc_q       <= disc_d;
            tuser0_q     <= tuser0_d;
`endif
        end
    end

    assign dn.s_axis_cc_tdata  = tdata_q;
    assign dn.s_axis_cc_tkeep  = tkeep_q;
    assign dn.s_axis_cc_tlast  = tlast_q;
    assign dn.s_axis_cc_tvalid = tvalid_q;
`ifdef CC_GEARBOX_DISCONTINUE_EN
    assign dn.s_axis_cc_tuser  = {32'b0, tuser0_q};
`else
    assign dn.s_axis_cc_tuser  = 33'b0;
`endif

endmodule

// File: tb/tb_cc_gearbox256.sv
// Scoreboard bench for cc_gearbox256: a DW-stream model predicts output beats, a monitor checks them.
// Define CC_GEARBOX_DISCONTINUE_EN to also exercise the discontinue path.

module tb_cc_gearbox256;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cc_user_if u ();
    cc_axis_if a ();

    cc_gearbox256 #(.DATA_WIDTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (u),
        .dn    (a)
    );

    typedef struct {
        logic [255:0] data;
        logic [7:0]   keep;
        logic         last;
        logic         tuser0;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    stall_cnt = 0;
    bit    rand_ready = 1'b0;
    int    pkt_no = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Sink backpressure: forced stalls, random, or always ready.
    initial begin
        a.s_axis_cc_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                a.s_axis_cc_tready = 1'b0;
                stall_cnt--;
            end else if (rand_ready) begin
                a.s_axis_cc_tready = ($urandom_range(0, 3) != 0);
            end else begin
                a.s_axis_cc_tready = 1'b1;
            end
        end
    end

    // Monitor: compares each handshaken beat against the scoreboard and checks stall hold.
    initial begin
        bit           prev_stall;
        logic [255:0] p_data;
        logic [7:0]   p_keep;
        logic         p_last;
        logic [32:0]  p_user;
        beat_t        e;
        prev_stall = 1'b0;
        p_data = '0; p_keep = '0; p_last = 1'b0; p_user = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    chk("hold_valid", 256'(a.s_axis_cc_tvalid), 256'(1));
                    chk("hold_data", a.s_axis_cc_tdata, p_data);
                    chk("hold_ctl", {a.s_axis_cc_tkeep, a.s_axis_cc_tlast, a.s_axis_cc_tuser},
                        {p_keep, p_last, p_user});
                end
                if (a.s_axis_cc_tvalid && !a.s_axis_cc_tready) begin
                    chk("ready_in_stall", 256'(u.cc_ready), 256'(0));
                end
                if (a.s_axis_cc_tvalid && a.s_axis_cc_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 256'(1), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", a.s_axis_cc_tdata, e.data);
                        chk("tkeep", 256'(a.s_axis_cc_tkeep), 256'(e.keep));
                        chk("tlast", 256'(a.s_axis_cc_tlast), 256'(e.last));
                        chk("tuser", 256'(a.s_axis_cc_tuser), 256'({32'b0, e.tuser0}));
                    end
                end
                prev_stall = a.s_axis_cc_tvalid && !a.s_axis_cc_tready;
                p_data = a.s_axis_cc_tdata;
                p_keep = a.s_axis_cc_tkeep;
                p_last = a.s_axis_cc_tlast;
                p_user = a.s_axis_cc_tuser;
            end
        end
    end

    // Builds the expected beats from the DW stream (3 descriptor DWs + payload), then drives the packet.
    task automatic send_packet(input int ndw, input bit disc_first, input int stall_at,
                               input bit gaps, output int waits);
        logic [95:0]  desc;
        logic [31:0]  pay[$];
        logic [31:0]  strm[$];
        bit           discs[$];
        bit           disc_any;
        int           nub, tot, nob, idx, wd;
        bit           hs;
        beat_t        b;
        logic [255:0] pl;
        logic [7:0]   kp;

        waits = 0;
        desc = {$urandom, $urandom, $urandom};
        for (int i = 0; i < ndw; i++) pay.push_back($urandom);
        nub = (ndw == 0) ? 1 : (ndw + 7) / 8;
        disc_any = 1'b0;
        for (int k = 0; k < nub; k++) begin
`ifdef CC_GEARBOX_DISCONTINUE_EN
            discs.push_back((k == 0 && disc_first) || (gaps && $urandom_range(0, 9) == 0));
`else
            discs.push_back(1'b0);
`endif
            disc_any |= discs[k];
        end

        for (int i = 0; i < 3; i++) strm.push_back(desc[32*i +: 32]);
        for (int i = 0; i < ndw; i++) strm.push_back(pay[i]);
        tot = 3 + ndw;
        nob = (tot + 7) / 8;
        for (int bi = 0; bi < nob; bi++) begin
            b.data = '0;
            b.keep = '0;
            for (int d = 0; d < 8; d++) begin
                idx = 8 * bi + d;
                if (idx < tot) begin
                    b.data[32*d +: 32] = strm[idx];
                    b.keep[d] = 1'b1;
                end
            end
            b.last = (bi == nob - 1);
            b.tuser0 = b.last && disc_any;
            exp_q.push_back(b);
        end

        for (int k = 0; k < nub; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                u.cc_valid = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            pl = '0;
            kp = '0;
            for (int d = 0; d < 8; d++) begin
                idx = 8 * k + d;
                if (idx < ndw) begin
                    pl[32*d +: 32] = pay[idx];
                    kp[d] = 1'b1;
                end
            end
            u.cc_valid           = 1'b1;
            u.cc_descriptor      = (k == 0) ? desc : {$urandom, $urandom, $urandom};
            u.cc_payload         = pl;
            u.cc_payload_dw_keep = kp;
            u.cc_payload_last    = (k == nub - 1);
`ifdef CC_GEARBOX_DISCONTINUE_EN
            u.cc_discontinue     = discs[k];
`endif
            if (k == stall_at) stall_cnt = 3;
            wd = 0;
            do begin
                @(negedge clk);
                hs = u.cc_ready;
                @(posedge clk);
                #1;
                wd++;
            end while (!hs && wd < 1000);
            if (!hs) chk("accept_timeout", 256'(0), 256'(1));
            waits += wd - 1;
        end
        u.cc_valid = 1'b0;
`ifdef CC_GEARBOX_DISCONTINUE_EN
        u.cc_discontinue = 1'b0;
`endif
        pkt_no++;
        $display("pkt %0d ndw=%0d user_beats=%0d out_beats=%0d disc=%0d waits=%0d",
                 pkt_no, ndw, nub, nob, disc_any, waits);
    endtask

    initial begin
        int w;
        int wd;
        u.cc_valid           = 1'b0;
        u.cc_descriptor      = '0;
        u.cc_payload         = '0;
        u.cc_payload_dw_keep = '0;
        u.cc_payload_last    = 1'b0;
`ifdef CC_GEARBOX_DISCONTINUE_EN
        u.cc_discontinue     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 256'(a.s_axis_cc_tvalid), 256'(0));
        chk("rst_tdata", a.s_axis_cc_tdata, 256'(0));
        chk("rst_tkeep", 256'(a.s_axis_cc_tkeep), 256'(0));
        chk("rst_tlast", 256'(a.s_axis_cc_tlast), 256'(0));
        chk("rst_tuser", 256'(a.s_axis_cc_tuser), 256'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cc_ready", 256'(u.cc_ready), 256'(1));

        send_packet(4, 1'b0, -1, 1'b0, w);
        send_packet(5, 1'b0, -1, 1'b0, w);
        chk("no_flush_stall", 256'(w), 256'(0));
        send_packet(1, 1'b0, -1, 1'b0, w);
        chk("after5_waits", 256'(w), 256'(0));
        send_packet(16, 1'b0, -1, 1'b0, w);
        send_packet(1, 1'b0, -1, 1'b0, w);
        chk("flush_bubble", 256'(w), 256'(1));
        send_packet(0, 1'b0, -1, 1'b0, w);
        send_packet(20, 1'b0, 1, 1'b0, w);
        send_packet(6, 1'b1, -1, 1'b0, w);
        send_packet(6, 1'b0, -1, 1'b0, w);

        rand_ready = 1'b1;
        repeat (60) send_packet($urandom_range(0, 40), 1'b0, -1, 1'b1, w);

        wd = 0;
        while (exp_q.size() != 0 && wd < 2000) begin
            @(posedge clk);
            wd++;
        end
        repeat (4) @(posedge clk);
        chk("drain_empty", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cc_gearbox256.md
# cc_gearbox256

Completer Completion (CC) transmit gearbox for the 256-bit PCIe AXI4-Stream interface. It takes DWORD-aligned completion payload from user logic plus a 96-bit CC descriptor and builds `s_axis_cc` beats. The descriptor occupies DW0–DW2 of the first beat and the payload is shifted up by 96 bits, so payload DW0 lands at bit 96. It sits between the completer-side user logic and the PCIe IP core CC port, and fully honours backpressure on both sides.

## Interface
Parameters:
- `DATA_WIDTH`, 256, stream width; only 256 is supported.

Ports (clock and reset first):
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cc_valid`  in  1  user beat valid.
- `cc_ready`  out  1  user beat accepted when `cc_valid && cc_ready`.
- `cc_descriptor`  in  96  CC descriptor; sampled only on the first beat of a packet.
- `cc_payload`  in  256  payload DWs 8k..8k+7 of user beat k.
- `cc_payload_dw_keep`  in  8  DW enables; contiguous from bit 0; 8'hFF on every non-last beat.
- `cc_payload_last`  in  1  last user beat of the packet.
- `s_axis_cc_tdata`  out  256  to the IP core.
- `s_axis_cc_tkeep`  out  8  DW enables.
- `s_axis_cc_tvalid`  out  1
- `s_axis_cc_tlast`  out  1
- `s_axis_cc_tuser`  out  33  bit 0 is discontinue (see Configuration); all other bits are 0.
- `s_axis_cc_tready`  in  1

## Operation
- Internal state:
  - output register: tdata, tkeep, tlast, tvalid.
  - `carry[95:0]`: upper 96 bits of the previous user beat.
  - `flush_keep[7:0]`: keep for a pending flush beat.
  - FSM with states IDLE, BODY, FLUSH.
- Slot-free condition: `slot_free = !s_axis_cc_tvalid || s_axis_cc_tready`.
- Ready: `cc_ready = slot_free && state != FLUSH`. This is a combinational path from `s_axis_cc_tready`.
- Let n = popcount(`cc_payload_dw_keep`) on the last beat.
- IDLE, beat accepted:
  - Output beat is {`cc_payload[159:0]`, `cc_descriptor`}.
  - `carry` <= `cc_payload[255:160]`.
  - If not last: tkeep FF, tlast 0, go to BODY.
  - If last and n ≤ 5: tkeep = mask(3+n) (low 3+n bits set), tlast 1, stay in IDLE.
  - If last and n > 5: tkeep FF, tlast 0, `flush_keep` = mask(n−5), go to FLUSH.
- BODY, beat accepted:
  - Output beat is {`cc_payload[159:0]`, `carry`}, and `carry` is updated.
  - Last-beat rules are the same as IDLE, but with n+3 counted from the carry: n ≤ 5 gives tkeep mask(3+n) and tlast, then IDLE; n > 5 gives tkeep FF, then FLUSH.
- FLUSH, when `slot_free`:
  - Output beat is {160'b0, `carry`}, tkeep `flush_keep`, tlast 1, then IDLE.
  - No user beat is accepted in FLUSH.
- Output beats per packet = ceil((3 + total payload DW)/8).
- Zero-payload completion: single beat with keep 8'h00 and last 1 gives one beat with tkeep 8'h07 and tlast 1.
- Gaps: `cc_valid` low mid-packet inserts idle cycles. The FSM holds its state and `carry`.
- Non-contiguous keep, or keep ≠ FF on a non-last beat, is illegal. Behaviour is undefined; it is not checked.

## Timing
- Latency: user accept to `s_axis_cc_tvalid` is 1 cycle (registered output).
- Throughput: 1 beat/cycle sustained with `s_axis_cc_tready` high. The only bubble is one `cc_ready`-low cycle per packet that needs a flush.
- Output hold: while `s_axis_cc_tvalid && !s_axis_cc_tready`, all `s_axis_cc_*` outputs hold stable and `cc_ready` is 0.
- tvalid drop: `s_axis_cc_tvalid` falls the cycle after a handshake if no new beat was loaded.
- Back-to-back packets: a new packet's first beat may be accepted in the same cycle the previous packet's last beat is handshaken. This holds for last beats from IDLE/BODY and for the FLUSH beat once it has left the output register.
- Reset values: `s_axis_cc_tvalid` 0, `tlast` 0, `tkeep` 0, `tdata` 0, `tuser` 0, state IDLE, `carry` 0. `cc_ready` reads 1 after reset.
- Reset mid-packet discards the in-flight packet. No partial beat or tlast is emitted.

## Configuration
- `CC_GEARBOX_DISCONTINUE_EN` defined:
  - Adds input `cc_discontinue` (1 bit).
  - It is sampled with every accepted user beat and OR-latched per packet.
  - `s_axis_cc_tuser[0]` = latched value on the packet's final output beat (including a FLUSH beat), and 0 on all other beats.
  - The latch clears when the final beat handshakes or on reset.
- Undefined: the port is absent and `s_axis_cc_tuser` is tied to 33'b0.

## Test plan
- Single beat, keep 8'h0F, last → one beat: tdata[95:0]=desc, tdata[223:96]=payload[127:0], tkeep 8'h7F, tlast 1.
- Single beat, keep 8'h1F (5 DW) → one beat, tkeep 8'hFF, tlast 1, no flush; `cc_ready` stays 1.
- Two full beats (16 DW) → three beats with tkeep FF, FF, 8'h07; tlast only on the third; `cc_ready` low for exactly one cycle.
- Zero payload (keep 8'h00, last) → one beat, tkeep 8'h07, tdata[95:0]=desc, tlast 1.
- `s_axis_cc_tready` low 3 cycles mid-packet → tdata/tkeep held stable, `cc_ready` 0, no beat lost or duplicated; per-DW scoreboard matches the input.
- With `CC_GEARBOX_DISCONTINUE_EN`: 6-DW packet with `cc_discontinue` on the first beat → tuser[0]=1 only on the flush beat (tkeep 8'h01); the next packet has tuser[0]=0.
